// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared types and sub-word slicing helper for the TCAM APT update path
package tcam_pkg;

  typedef enum logic {
    OP_DELETE = 1'b0,
    OP_INSERT = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_W = 256;

  // Sub-word j counted from the MSB end; callers truncate the result to sw bits.
  function automatic logic [MAX_W-1:0] subword(input logic [MAX_W-1:0] value,
                                               input int total_w,
                                               input int j,
                                               input int sw);
    logic [MAX_W-1:0] field_mask;
    field_mask = (MAX_W'(1) << sw) - MAX_W'(1);
    return (value >> (total_w - (j + 1) * sw)) & field_mask;
  endfunction

endpackage

// File: rtl/tcam_apt_update_ctrl_if.sv
// rtl/tcam_apt_update_ctrl_if.sv - rule request handshake plus APT column-write bus
interface tcam_apt_update_ctrl_if #(
  parameter int N = 2,
  parameter int W = 32,
  parameter int K = 256
);
  localparam int w  = W / N;
  localparam int IW = $clog2(K);

  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_op;
  logic [IW-1:0] i_idx;
  logic [W-1:0]  i_value;
  logic [W-1:0]  i_mask;
  logic [0:N-1]  o_apt_we;
  logic [w-1:0]  o_apt_addr;
  logic [IW-1:0] o_apt_col;
  logic [0:N-1]  o_apt_bit;

  modport master (
    output i_req_valid, i_op, i_idx, i_value, i_mask,
    input  o_req_ready, o_apt_we, o_apt_addr, o_apt_col, o_apt_bit
  );

  modport slave (
    input  i_req_valid, i_op, i_idx, i_value, i_mask,
    output o_req_ready, o_apt_we, o_apt_addr, o_apt_col, o_apt_bit
  );

endinterface

// File: rtl/tcam_subword_match.sv
// rtl/tcam_subword_match.sv - ternary compare of one APT row address against a rule sub-word
module tcam_subword_match #(
  parameter int w = 16
) (
  input  logic [w-1:0] i_addr,
  input  logic [w-1:0] i_value,
  input  logic [w-1:0] i_mask,
  output logic         o_match
);

  assign o_match = (((i_addr ^ i_value) & ~i_mask) == '0);

endmodule

// File: rtl/tcam_apt_update_ctrl.sv
// rtl/tcam_apt_update_ctrl.sv - sweeps all APT rows to write one rule column across N tables
module tcam_apt_update_ctrl
  import tcam_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32,
  parameter int K = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  tcam_apt_update_ctrl_if.slave  bus,
  output logic                   o_search_block,
  output logic                   o_done,
  output logic [0:K-1]           o_rule_valid
);

  localparam int w  = W / N;
  localparam int IW = $clog2(K);

  state_e        state_q;
  op_e           op_q;
  logic [w-1:0]  addr_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  value_q;
  logic [W-1:0]  mask_q;
  logic          ready_q;
  logic [0:N-1]  we_q;
  logic [0:N-1]  bit_q;
  logic          sb_q;
  logic          done_q;
  logic [0:K-1]  rv_q;

  // Outputs are registered, so the bit for the next row is computed one cycle early.
  logic [w-1:0]  nxt_addr_d;
  logic [W-1:0]  nxt_value_d;
  logic [W-1:0]  nxt_mask_d;
  logic          nxt_insert_d;
  logic [0:N-1]  match;
  logic [0:N-1]  nxt_bits_d;

  always_comb begin
    nxt_addr_d   = addr_q + w'(1);
    nxt_value_d  = value_q;
    nxt_mask_d   = mask_q;
    nxt_insert_d = (op_q == OP_INSERT);
    if (state_q == IDLE) begin
      nxt_addr_d   = '0;
      nxt_value_d  = bus.i_value;
      nxt_mask_d   = bus.i_mask;
      nxt_insert_d = (op_e'(bus.i_op) == OP_INSERT);
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_tbl
    logic [w-1:0] value_j;
    logic [w-1:0] mask_j;
    assign value_j = w'(subword(MAX_W'(nxt_value_d), W, j, w));
    assign mask_j  = w'(subword(MAX_W'(nxt_mask_d), W, j, w));
    tcam_subword_match #(.w(w)) u_match (
      .i_addr  (nxt_addr_d),
      .i_value (value_j),
      .i_mask  (mask_j),
      .o_match (match[j])
    );
  end

  assign nxt_bits_d = nxt_insert_d ? match : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_DELETE;
      addr_q  <= '0;
      idx_q   <= '0;
      value_q <= '0;
      mask_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= '0;
      bit_q   <= '0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          we_q    <= '0;
          bit_q   <= '0;
          sb_q    <= 1'b0;
          if (bus.i_req_valid && ready_q) begin
            op_q    <= op_e'(bus.i_op);
            idx_q   <= bus.i_idx;
            value_q <= bus.i_value;
            mask_q  <= bus.i_mask;
            ready_q <= 1'b0;
            // Deleting a rule that is not present leaves the tables untouched.
            if (nxt_insert_d || rv_q[bus.i_idx]) begin
              state_q <= SWEEP;
              addr_q  <= '0;
              we_q    <= '1;
              bit_q   <= nxt_bits_d;
              sb_q    <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SWEEP: begin
          if (addr_q == '1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            we_q    <= '0;
            bit_q   <= '0;
            sb_q    <= 1'b0;
          end else begin
            addr_q <= nxt_addr_d;
            bit_q  <= nxt_bits_d;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_q       <= 1'b0;
          ready_q      <= 1'b1;
          rv_q[idx_q]  <= (op_q == OP_INSERT);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_apt_we    = we_q;
  assign bus.o_apt_addr  = addr_q;
  assign bus.o_apt_col   = idx_q;
  assign bus.o_apt_bit   = bit_q;
  assign o_search_block  = sb_q;
  assign o_done          = done_q;
  assign o_rule_valid    = rv_q;

endmodule

// File: tb/tb_tcam_apt_update_ctrl.sv
// tb/tb_tcam_apt_update_ctrl.sv - directed self-checking bench for tcam_apt_update_ctrl (W=8, N=2, K=8)
module tb_tcam_apt_update_ctrl;

  logic       clk;
  logic       rst;
  logic       search_block;
  logic       done;
  logic [0:7] rule_valid;

  int errors;
  int checks;

  tcam_apt_update_ctrl_if #(.N(2), .W(8), .K(8)) bus ();

  tcam_apt_update_ctrl #(.N(2), .W(8), .K(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_search_block (search_block),
    .o_done         (done),
    .o_rule_valid   (rule_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at the first sweep cycle; rows where table 0 / table 1 must be written with 1.
  task automatic sweep_check(input logic [2:0] idx, input logic [15:0] e0, input logic [15:0] e1);
    for (int a = 0; a < 16; a++) begin
      chk("sweep_we", 32'(bus.o_apt_we), 32'h3);
      chk("sweep_addr", 32'(bus.o_apt_addr), 32'(a));
      chk("sweep_col", 32'(bus.o_apt_col), 32'(idx));
      chk("sweep_bit", 32'(bus.o_apt_bit), 32'({e0[a], e1[a]}));
      chk("sweep_sb", 32'(search_block), 32'h1);
      chk("sweep_ready", 32'(bus.o_req_ready), 32'h0);
      chk("sweep_done", 32'(done), 32'h0);
      tick();
    end
    chk("done_pulse", 32'(done), 32'h1);
    chk("done_we", 32'(bus.o_apt_we), 32'h0);
    chk("done_bit", 32'(bus.o_apt_bit), 32'h0);
    chk("done_sb", 32'(search_block), 32'h0);
    chk("done_ready", 32'(bus.o_req_ready), 32'h0);
    tick();
  endtask

  task automatic drive(input logic op, input logic [2:0] idx, input logic [7:0] value, input logic [7:0] mask);
    bus.i_req_valid = 1'b1;
    bus.i_op        = op;
    bus.i_idx       = idx;
    bus.i_value     = value;
    bus.i_mask      = mask;
  endtask

  task automatic do_req(input logic op, input logic [2:0] idx, input logic [7:0] value,
                        input logic [7:0] mask, input logic sweep,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [7:0] erv);
    chk("idle_ready", 32'(bus.o_req_ready), 32'h1);
    chk("idle_sb", 32'(search_block), 32'h0);
    drive(op, idx, value, mask);
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_value     = ~value;
    bus.i_mask      = ~mask;
    bus.i_idx       = ~idx;
    if (sweep) begin
      sweep_check(idx, e0, e1);
    end else begin
      chk("skip_done", 32'(done), 32'h1);
      chk("skip_we", 32'(bus.o_apt_we), 32'h0);
      chk("skip_sb", 32'(search_block), 32'h0);
      chk("skip_ready", 32'(bus.o_req_ready), 32'h0);
      tick();
    end
    chk("after_ready", 32'(bus.o_req_ready), 32'h1);
    chk("after_done", 32'(done), 32'h0);
    chk("after_rv", 32'(rule_valid), 32'(erv));
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_op        = 1'b0;
    bus.i_idx       = '0;
    bus.i_value     = '0;
    bus.i_mask      = '0;

    tick();
    chk("rst_ready", 32'(bus.o_req_ready), 32'h0);
    chk("rst_we", 32'(bus.o_apt_we), 32'h0);
    chk("rst_bit", 32'(bus.o_apt_bit), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sb", 32'(search_block), 32'h0);
    chk("rst_rv", 32'(rule_valid), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("release_ready_low", 32'(bus.o_req_ready), 32'h0);
    tick();
    chk("release_ready_high", 32'(bus.o_req_ready), 32'h1);
    chk("release_rv", 32'(rule_valid), 32'h0);

    // Exact match: table 0 row 0xA, table 1 row 0x5; rule_valid ordering [0:7] puts idx 3 at 8'h10.
    do_req(1'b1, 3'd3, 8'hA5, 8'h00, 1'b1, 16'h0400, 16'h0020, 8'h10);
    // Low sub-word fully masked: table 1 writes 1 everywhere, table 0 only at row 3.
    do_req(1'b1, 3'd0, 8'h30, 8'h0F, 1'b1, 16'h0008, 16'hFFFF, 8'h90);
    do_req(1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000, 8'h80);
    do_req(1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 8'h80);

    // Valid held high through a sweep: the second handshake happens only after DONE.
    drive(1'b1, 3'd5, 8'hFF, 8'hFF);
    tick();
    sweep_check(3'd5, 16'hFFFF, 16'hFFFF);
    chk("b2b_ready", 32'(bus.o_req_ready), 32'h1);
    chk("b2b_rv", 32'(rule_valid), 32'h84);
    drive(1'b0, 3'd5, 8'h00, 8'h00);
    tick();
    bus.i_req_valid = 1'b0;
    sweep_check(3'd5, 16'h0000, 16'h0000);
    chk("b2b_rv_del", 32'(rule_valid), 32'h80);
    tick();
    chk("b2b_no_extra_we", 32'(bus.o_apt_we), 32'h0);
    chk("b2b_no_extra_sb", 32'(search_block), 32'h0);
    chk("b2b_ready_idle", 32'(bus.o_req_ready), 32'h1);

    // Reset lands mid-sweep at row 7.
    drive(1'b1, 3'd2, 8'h00, 8'h00);
    tick();
    bus.i_req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_addr", 32'(bus.o_apt_addr), 32'h7);
    chk("mid_we", 32'(bus.o_apt_we), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_we", 32'(bus.o_apt_we), 32'h0);
    chk("async_sb", 32'(search_block), 32'h0);
    chk("async_rv", 32'(rule_valid), 32'h0);
    chk("async_ready", 32'(bus.o_req_ready), 32'h0);
    chk("async_addr", 32'(bus.o_apt_addr), 32'h0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    chk("rerelease_ready", 32'(bus.o_req_ready), 32'h1);
    do_req(1'b1, 3'd6, 8'h12, 8'h00, 1'b1, 16'h0002, 16'h0004, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcam_apt_update_ctrl.md
Name: tcam_apt_update_ctrl

Overview:
- Write-side controller for the SRAM-based TCAM layer: turns one ternary rule (value/mask, rule index) into per-column writes of the N APT SRAM tables.
- The search path reads those APT rows and ANDs them into the match vector feeding the LPE. This block writes them.
- Sweeps every APT row address once per request, writing the rule's column bit in all N tables in parallel.
- Keeps a rule-valid bitmap. Asserts a search-block flag while tables are inconsistent.

Parameters:
- N, 2, number of sub-words / APT tables per layer
- W, 32, rule width in bits; W % N must be 0
- K, 256, number of rules (APT row width, LPE input width)
- Derived localparams: w = W/N (APT address width), IW = $clog2(K)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready
- i_op  in  1  1 = insert, 0 = delete
- i_idx  in  IW  rule index (column); 0 = highest priority
- i_value  in  W  rule value
- i_mask  in  W  don't-care mask; 1 = don't care
- o_apt_we  out  [0:N-1]  per-table column write enable
- o_apt_addr  out  w  APT row address
- o_apt_col  out  IW  column being written
- o_apt_bit  out  [0:N-1]  bit value written per table
- o_search_block  out  1  high while a sweep is in progress; gates search enable
- o_done  out  1  one-cycle completion pulse
- o_rule_valid  out  [0:K-1]  rule-valid bitmap, same ordering as PMA

Behaviour:
- Sub-word j (j = 0..N-1) is i_value[W-1-j*w -: w]. j = 0 is the MSB sub-word, matching search-path ordering. Table j receives o_apt_we[j] and o_apt_bit[j].
- FSM states: IDLE, SWEEP, DONE. All outputs are registered.
- Reset (async): state = IDLE; all outputs 0, including o_req_ready and o_rule_valid. o_req_ready rises the first clock after rst deasserts.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid & o_req_ready at edge t: latch op/idx/value/mask.
  - If insert, or delete with o_rule_valid[idx] = 1: go to SWEEP with addr counter = 0.
  - If delete with o_rule_valid[idx] = 0: go straight to DONE; no writes issued.
- SWEEP:
  - Each cycle: o_apt_we = all 1s, o_apt_addr = counter, o_apt_col = latched idx, o_search_block = 1.
  - o_apt_bit[j] = insert ? (((addr ^ value_j) & ~mask_j) == 0) : 0.
  - Counter increments every cycle. After the cycle with addr = 2^w-1, go to DONE.
  - Exactly 2^w write cycles, occupying cycles t+1 .. t+2^w.
- DONE:
  - One cycle: o_done = 1, o_apt_we = 0, o_search_block = 0, o_req_ready = 0.
  - o_rule_valid[idx] is set on insert and cleared on delete; the new value is visible the cycle after DONE.
  - Then return to IDLE.
  - Total: done at t+2^w+1; next request can be accepted at t+2^w+2.
- o_req_ready = 0 in SWEEP and DONE. i_req_valid is ignored outside IDLE; inputs need not be held after acceptance.
- Insert to an already-valid idx: full overwrite sweep; the bit stays set.
- Mask all 1s: every row gets bit = 1. Mask all 0s: exactly one row per table gets bit = 1.
- Reset mid-SWEEP: abort immediately, outputs go to reset values, bitmap is cleared. The APT contents are undefined; software must re-insert rules.
- o_apt_we and o_apt_bit are 0 whenever not in SWEEP.

Decomposition:
- tcam_pkg holds:
  - the op enum (OP_DELETE = 0, OP_INSERT = 1)
  - the FSM state enum
  - a subword function: value, index, w → slice
- Sub-module tcam_subword_match: purely combinational, one instance per table. Inputs: addr[w], value_j[w], mask_j[w]. Output: match bit.

Test Plan (run at W=8, N=2, K=8, so w=4 and 16 rows):
- Reset release: rst held 3 cycles then low → all outputs 0 during reset; o_req_ready = 1 one cycle after release; o_rule_valid = 8'h00.
- Insert idx=3, value=8'hA5, mask=8'h00 → writes at addr 0..15, col=3. Table 0 bit=1 only at addr 0xA; table 1 bit=1 only at addr 0x5. o_done at cycle t+17; o_rule_valid[3] = 1.
- Insert idx=0, value=8'h30, mask=8'h0F → table 1 bit=1 at all 16 addrs; table 0 bit=1 only at addr 3. o_search_block high for exactly 16 cycles.
- Delete idx=3 (valid) → 16 writes with bit=0, col=3; o_rule_valid[3] = 0. A second delete of idx=3 → no we, o_done at t+1, ready again at t+2.
- Back-to-back valid held high during SWEEP → second request accepted only in IDLE after DONE; exactly one sweep per handshake.
- rst asserted at SWEEP addr=7 → we drops asynchronously, o_rule_valid = 0; a new insert after release completes normally.
